serial_rx_controller: RTL

Control FSM for the serial receiver datapath. It sequences the external 8-bit bit counter through its ClearCounter and IncCounter inputs and reads back Count. It also holds an internal oversampling counter, a shift register and an output holding register. A valid/ack handshake presents each received frame to the downstream consumer. Frame format: 1 start bit (0), DATA_BITS data bits sent LSB first, then 1 stop bit (1).

---
 rtl/serial_rx_controller_pkg.sv | 15 +
 rtl/serial_rx_controller_sample_counter.sv | 32 +++
 rtl/serial_rx_controller.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_rx_controller_pkg.sv
// Shared types and default sizing for the serial receiver controller.
package serial_rx_controller_pkg;

    localparam int unsigned DEF_DATA_BITS  = 8;
    localparam int unsigned DEF_OVERSAMPLE = 16;
    localparam int unsigned DEF_SAMPLE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/serial_rx_controller_sample_counter.sv
// Oversampling counter: synchronous clear has priority over enable;
// tc flags that the count equals the supplied terminal value.
module sample_counter
    import serial_rx_controller_pkg::*;
#(
    parameter int unsigned SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] tc_value,
    output logic                tc
);

    logic [SAMPLE_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    always_comb begin
        tc = (count == tc_value);
    end

endmodule

// File: rtl/serial_rx_controller.sv
// Receive-side control FSM: sequences the external bit counter, samples
// mid-bit, assembles frames and hands them off over a valid/ack handshake.
module serial_rx_controller
    import serial_rx_controller_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_serial,
    input  logic [7:0]           Count,
    output logic                 ClearCounter,
    output logic                 IncCounter,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    input  logic                 err_clr,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam logic [SAMPLE_W-1:0] HALF_TC  = SAMPLE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMPLE_W-1:0] FULL_TC  = SAMPLE_W'(OVERSAMPLE - 1);
    localparam logic [7:0]          LAST_BIT = 8'(DATA_BITS - 1);

    rx_state_t            state;
    logic                 sync1;
    logic                 rx_s;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [SAMPLE_W-1:0]  tc_value;
    logic                 tc;
    logic                 sample_clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_serial;
            rx_s  <= sync1;
        end
    end

    // START times a half bit to reach mid-start; DATA/STOP time full bits.
    // Clearing on tc gives the wrap in DATA and a fresh count on each transition.
    always_comb begin
        tc_value     = (state == ST_START) ? HALF_TC : FULL_TC;
        sample_clear = (state == ST_IDLE) || tc;
        shift_next   = DATA_BITS'({rx_s, shift_reg} >> 1);
        ClearCounter = (state == ST_IDLE);
        IncCounter   = (state == ST_DATA) && tc;
        busy         = (state != ST_IDLE);
    end

    sample_counter #(
        .SAMPLE_W(SAMPLE_W)
    ) u_sample_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (sample_clear),
        .enable   (busy),
        .tc_value (tc_value),
        .tc       (tc)
    );

    // Flag clears and the ack drop come first so a same-cycle set or load wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (err_clr) begin
                framing_err <= 1'b0;
                overrun_err <= 1'b0;
            end
            if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (!rx_s) state <= ST_START;
                end
                ST_START: begin
                    if (tc) state <= rx_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (tc) begin
                        shift_reg <= shift_next;
                        if (Count == LAST_BIT) state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tc) begin
                        state <= ST_IDLE;
                        if (rx_s) begin
                            if (!rx_valid || rx_ack) begin
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end else begin
                            framing_err <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
